scroll_window_gen: RTL and testbench

Parametrised scroll-window generator for the LED word panel. It produces the `start`/`stop` character indices of the visible window as the window slides across a message buffer, one position per scroll tick. It sits between the scroll-rate divider, which supplies `sclk`, and the panel column/character fetch logic, which consumes `start`/`stop`. It adds runtime message length, loop and bounce modes, reverse direction, end-of-message pause and single-step edge detection on `sclk`.

---
 rtl/scroll_window_gen.sv | 228 ++++++++++++++++++++++
 tb/tb_scroll_window_gen.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scroll_window_gen.sv
// scroll_window_gen
// Produces the start/stop character indices of the visible panel window as it
// slides across a message buffer, one position per rising edge of sclk.
// Supports loop and bounce travel, reverse loop direction, a dwell of
// PAUSE_TICKS scroll ticks at each end of travel, and a runtime message length.
//
// Build option: define SCROLL_BOUNCE_EN to build bounce mode. With the macro
// undefined, i_mode is ignored and only loop travel exists.
module scroll_window_gen #(
    parameter int IDX_W       = 7,
    parameter int WIN_LEN     = 24,
    parameter int PAUSE_TICKS = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_sclk,
    input  logic             i_enable,
    input  logic             i_restart,
    input  logic [IDX_W-1:0] i_msg_len,
    input  logic             i_rev,
    input  logic             i_mode,
    output logic [IDX_W-1:0] o_start,
    output logic [IDX_W-1:0] o_stop,
    output logic             o_dir,
    output logic             o_wrap,
    output logic             o_busy
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SCROLL = 2'd1;
    localparam logic [1:0] ST_PAUSE  = 2'd2;

    // Dwell counter runs 0 .. PAUSE_TICKS-1
    localparam int              PC_W      = (PAUSE_TICKS > 1) ? $clog2(PAUSE_TICKS) : 1;
    localparam logic [PC_W-1:0] PC_LAST   = (PAUSE_TICKS > 0) ? PC_W'(PAUSE_TICKS - 1) : {PC_W{1'b0}};
    localparam logic [PC_W-1:0] PC_ZERO   = {PC_W{1'b0}};
    localparam logic [PC_W-1:0] PC_ONE    = PC_W'(1);
    localparam logic [IDX_W-1:0] POS_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] POS_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] STOP_OFS = IDX_W'(WIN_LEN - 1);
    localparam logic [IDX_W:0]   WIN_EXT  = (IDX_W + 1)'(WIN_LEN);
    localparam bit               HAS_PAUSE = (PAUSE_TICKS > 0);

    // Furthest start index: message length minus window, floored at zero.
    // Done one bit wider so the comparison and subtraction cannot underflow.
    function automatic logic [IDX_W-1:0] max_pos_f(input logic [IDX_W-1:0] len);
        logic [IDX_W:0] len_ext;
        logic [IDX_W:0] diff;
        len_ext = {1'b0, len};
        if (len_ext > WIN_EXT) begin
            diff = len_ext - WIN_EXT;
        end else begin
            diff = {(IDX_W + 1){1'b0}};
        end
        return diff[IDX_W-1:0];
    endfunction

    logic [1:0]       r_state;
    logic [IDX_W-1:0] r_pos;
    logic [IDX_W-1:0] r_stop;
    logic             r_dir;
    logic             r_wrap;
    logic             r_busy;
    logic [PC_W-1:0]  r_pcnt;
    logic [IDX_W-1:0] r_len;
    logic             r_mode;
    logic             r_sclk_q;

    logic             w_step;
    logic             w_mode_live;
    logic             w_loop_rev_live;
    logic [IDX_W-1:0] w_max_live;
    logic [IDX_W-1:0] w_max_lat;
    logic [IDX_W-1:0] w_end_pos;
    logic [IDX_W-1:0] w_pos_move;
    logic             w_turn;
    logic [1:0]       w_state_nxt;
    logic [IDX_W-1:0] w_pos_nxt;
    logic             w_dir_nxt;
    logic             w_wrap_nxt;
    logic [PC_W-1:0]  w_pcnt_nxt;
    logic [IDX_W-1:0] w_len_nxt;
    logic             w_mode_nxt;

`ifdef SCROLL_BOUNCE_EN
    assign w_mode_live = i_mode;
`else
    logic w_unused_mode;
    assign w_unused_mode = i_mode;
    assign w_mode_live   = 1'b0;
`endif

    // One step per low-to-high transition of the scroll tick
    assign w_step          = i_sclk & ~r_sclk_q;
    assign w_loop_rev_live = ~w_mode_live & i_rev;
    assign w_max_live      = max_pos_f(i_msg_len);
    assign w_max_lat       = max_pos_f(r_len);
    assign w_end_pos       = r_dir ? POS_ZERO : w_max_lat;
    assign w_pos_move      = r_dir ? (r_pos - POS_ONE) : (r_pos + POS_ONE);

    // Next state, window position, direction, dwell count and wrap pulse
    always_comb begin
        w_state_nxt = r_state;
        w_pos_nxt   = r_pos;
        w_dir_nxt   = r_dir;
        w_pcnt_nxt  = r_pcnt;
        w_wrap_nxt  = 1'b0;
        w_len_nxt   = r_len;
        w_mode_nxt  = r_mode;
        w_turn      = 1'b0;
        if (i_restart) begin
            w_state_nxt = ST_IDLE;
            w_pos_nxt   = POS_ZERO;
            w_dir_nxt   = 1'b0;
            w_pcnt_nxt  = PC_ZERO;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Track the live configuration so the edge that leaves
                    // IDLE latches exactly the values present at that edge.
                    w_len_nxt  = i_msg_len;
                    w_mode_nxt = w_mode_live;
                    w_dir_nxt  = w_loop_rev_live;
                    w_pcnt_nxt = PC_ZERO;
                    if (w_loop_rev_live) begin
                        w_pos_nxt = w_max_live;
                    end else begin
                        w_pos_nxt = POS_ZERO;
                    end
                    if (i_enable) begin
                        w_state_nxt = ST_SCROLL;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_SCROLL: begin
                    if (i_enable && w_step) begin
                        if (r_pos != w_end_pos) begin
                            w_pos_nxt = w_pos_move;
                            if (HAS_PAUSE && (w_pos_move == w_end_pos)) begin
                                w_state_nxt = ST_PAUSE;
                                w_pcnt_nxt  = PC_ZERO;
                            end else begin
                                w_state_nxt = ST_SCROLL;
                            end
                        end else if (w_max_lat != POS_ZERO) begin
                            // Already at the end with no dwell configured
                            w_turn = 1'b1;
                        end else begin
                            // Message fits in the window: static, never wraps
                            w_state_nxt = ST_SCROLL;
                        end
                    end else begin
                        w_state_nxt = ST_SCROLL;
                    end
                end
                ST_PAUSE: begin
                    if (i_enable && w_step) begin
                        if (r_pcnt == PC_LAST) begin
                            w_turn = 1'b1;
                        end else begin
                            w_pcnt_nxt = r_pcnt + PC_ONE;
                        end
                    end else begin
                        w_state_nxt = ST_PAUSE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase

            if (w_turn) begin
                w_wrap_nxt  = 1'b1;
                w_state_nxt = ST_SCROLL;
                w_pcnt_nxt  = PC_ZERO;
                if (r_mode) begin
`ifdef SCROLL_BOUNCE_EN
                    // Bounce: reverse travel, window stays put on this step
                    w_dir_nxt = ~r_dir;
`else
                    w_dir_nxt = r_dir;
`endif
                end else if (r_dir) begin
                    w_pos_nxt = w_max_lat;
                end else begin
                    w_pos_nxt = POS_ZERO;
                end
            end else begin
                w_wrap_nxt = 1'b0;
            end
        end
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= ST_IDLE;
            r_pos    <= POS_ZERO;
            r_stop   <= STOP_OFS;
            r_dir    <= 1'b0;
            r_wrap   <= 1'b0;
            r_busy   <= 1'b0;
            r_pcnt   <= PC_ZERO;
            r_len    <= POS_ZERO;
            r_mode   <= 1'b0;
            r_sclk_q <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pos    <= w_pos_nxt;
            r_stop   <= w_pos_nxt + STOP_OFS;
            r_dir    <= w_dir_nxt;
            r_wrap   <= w_wrap_nxt;
            r_busy   <= (w_state_nxt != ST_IDLE);
            r_pcnt   <= w_pcnt_nxt;
            r_len    <= w_len_nxt;
            r_mode   <= w_mode_nxt;
            r_sclk_q <= i_sclk;
        end
    end

    assign o_start = r_pos;
    assign o_stop  = r_stop;
    assign o_dir   = r_dir;
    assign o_wrap  = r_wrap;
    assign o_busy  = r_busy;

endmodule

// File: tb/tb_scroll_window_gen.sv
// Testbench for scroll_window_gen: directed scenarios plus randomized traffic,
// checked every cycle against a behavioural model through a scoreboard queue.
module tb_scroll_window_gen;

    localparam int IDX_W = 7;
    localparam int WIN   = 24;
    localparam int PT    = 4;
`ifdef SCROLL_BOUNCE_EN
    localparam bit BOUNCE = 1'b1;
`else
    localparam bit BOUNCE = 1'b0;
`endif

    typedef struct packed {
        logic [IDX_W-1:0] start;
        logic [IDX_W-1:0] stop;
        logic             dir;
        logic             wrap;
        logic             busy;
    } obs_t;

    logic             clk;
    logic             reset;
    logic             sclk;
    logic             enable;
    logic             restart;
    logic [IDX_W-1:0] msg_len;
    logic             rev;
    logic             mode;
    logic [IDX_W-1:0] o_start;
    logic [IDX_W-1:0] o_stop;
    logic             o_dir;
    logic             o_wrap;
    logic             o_busy;

    int n_checks = 0;
    int n_errors = 0;
    obs_t exp_q[$];

    // Behavioural model state
    bit m_run;
    int m_pos;
    bit m_dir;
    bit m_wrap;
    bit m_mode;
    int m_len;
    int m_dwell;   // scroll ticks still to dwell at the current end
    bit m_sq;

    scroll_window_gen #(.IDX_W(IDX_W), .WIN_LEN(WIN), .PAUSE_TICKS(PT)) dut (
        .i_clk(clk), .i_reset(reset), .i_sclk(sclk), .i_enable(enable),
        .i_restart(restart), .i_msg_len(msg_len), .i_rev(rev), .i_mode(mode),
        .o_start(o_start), .o_stop(o_stop), .o_dir(o_dir), .o_wrap(o_wrap),
        .o_busy(o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int maxp(int len);
        return (len > WIN) ? len - WIN : 0;
    endfunction

    task automatic model_reset();
        m_run = 1'b0; m_pos = 0; m_dir = 1'b0; m_wrap = 1'b0;
        m_mode = 1'b0; m_len = 0; m_dwell = 0; m_sq = 1'b0;
    endtask

    task automatic end_of_travel();
        m_wrap = 1'b1;
        if (m_mode) m_dir = ~m_dir;
        else m_pos = m_dir ? maxp(m_len) : 0;
    endtask

    // Advance the model by one clk edge using the inputs the DUT sampled
    task automatic model_edge();
        bit step;
        int mx;
        int goal;
        if (reset) begin
            model_reset();
            return;
        end
        step   = sclk && !m_sq;
        m_sq   = sclk;
        m_wrap = 1'b0;
        if (restart) begin
            m_run = 1'b0; m_pos = 0; m_dir = 1'b0; m_dwell = 0;
            return;
        end
        if (!m_run) begin
            m_len   = int'(msg_len);
            m_mode  = BOUNCE ? mode : 1'b0;
            m_dir   = m_mode ? 1'b0 : rev;
            m_pos   = (!m_mode && rev) ? maxp(m_len) : 0;
            m_dwell = 0;
            m_run   = enable;
        end else if (enable && step) begin
            mx   = maxp(m_len);
            goal = m_dir ? 0 : mx;
            if (m_dwell > 0) begin
                m_dwell--;
                if (m_dwell == 0) end_of_travel();
            end else if (mx == 0) begin
                m_pos = 0;
            end else if (m_pos == goal) begin
                end_of_travel();
            end else begin
                m_pos = m_dir ? m_pos - 1 : m_pos + 1;
                if (m_pos == goal) m_dwell = PT;
            end
        end
    endtask

    function automatic obs_t model_obs();
        obs_t e;
        e.start = IDX_W'(m_pos);
        e.stop  = IDX_W'(m_pos + WIN - 1);
        e.dir   = m_dir;
        e.wrap  = m_wrap;
        e.busy  = m_run;
        return e;
    endfunction

    // One clock: model follows the edge and queues what the DUT must show
    task automatic tick();
        @(posedge clk);
        model_edge();
        exp_q.push_back(model_obs());
        #1;
    endtask

    task automatic pulse(int n);
        for (int i = 0; i < n; i++) begin
            sclk = 1'b1; tick();
            sclk = 1'b0; tick();
        end
    endtask

    task automatic chk(string name, int got, int want);
        n_checks++;
        if (got != want) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", name, got, want);
        end
    endtask

    // Scoreboard monitor: compare every presented output set mid-cycle
    always @(negedge clk) begin
        obs_t e;
        obs_t g;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = '{start: o_start, stop: o_stop, dir: o_dir, wrap: o_wrap, busy: o_busy};
            n_checks++;
            if (g !== e) begin
                n_errors++;
                $display("FAIL scoreboard t=%0t got start=%0d stop=%0d dir=%0b wrap=%0b busy=%0b expected start=%0d stop=%0d dir=%0b wrap=%0b busy=%0b",
                         $time, g.start, g.stop, g.dir, g.wrap, g.busy,
                         e.start, e.stop, e.dir, e.wrap, e.busy);
            end
        end
    end

    // Safety net so the run always ends
    initial begin
        #2000000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int wraps;
        model_reset();
        reset = 1'b1; sclk = 1'b0; enable = 1'b0; restart = 1'b0;
        msg_len = 7'd48; rev = 1'b0; mode = 1'b0;
        tick(); tick();
        chk("reset_start", int'(o_start), 0);
        chk("reset_stop", int'(o_stop), 23);
        chk("reset_dir", int'(o_dir), 0);
        chk("reset_wrap", int'(o_wrap), 0);
        chk("reset_busy", int'(o_busy), 0);

        // Forward loop over a 48-character message
        reset = 1'b0; enable = 1'b1;
        tick();
        chk("fwd_busy", int'(o_busy), 1);
        pulse(24);
        chk("fwd_end_start", int'(o_start), 24);
        chk("fwd_end_stop", int'(o_stop), 47);
        pulse(3);
        chk("fwd_dwell_start", int'(o_start), 24);
        sclk = 1'b1; tick();
        chk("fwd_reload_start", int'(o_start), 0);
        chk("fwd_reload_stop", int'(o_stop), 23);
        chk("fwd_wrap_on", int'(o_wrap), 1);
        sclk = 1'b0; tick();
        chk("fwd_wrap_off", int'(o_wrap), 0);

        // sclk held high gives one step; steps while disabled are dropped
        sclk = 1'b1;
        repeat (50) tick();
        sclk = 1'b0; tick();
        chk("held_sclk_start", int'(o_start), 1);
        enable = 1'b0;
        pulse(3);
        chk("disabled_start", int'(o_start), 1);
        enable = 1'b1;

        // Reverse loop over 30 characters
        restart = 1'b1; rev = 1'b1; msg_len = 7'd30;
        tick();
        chk("restart_busy", int'(o_busy), 0);
        restart = 1'b0;
        tick();
        chk("rev_first_start", int'(o_start), 6);
        chk("rev_dir", int'(o_dir), 1);
        pulse(6);
        chk("rev_end_start", int'(o_start), 0);
        pulse(3);
        sclk = 1'b1; tick();
        chk("rev_reload_start", int'(o_start), 6);
        chk("rev_wrap_on", int'(o_wrap), 1);
        sclk = 1'b0; tick();

        // Asynchronous reset in the middle of the dwell
        pulse(8);
        @(negedge clk); #1;
        reset = 1'b1;
        model_reset();
        #1;
        chk("async_reset_start", int'(o_start), 0);
        chk("async_reset_stop", int'(o_stop), 23);
        chk("async_reset_dir", int'(o_dir), 0);
        chk("async_reset_busy", int'(o_busy), 0);
        tick(); tick();
        reset = 1'b0; rev = 1'b0; msg_len = 7'd48;
        tick();
        pulse(1);
        chk("after_reset_step", int'(o_start), 1);

        // Restart in the middle of the dwell, then a message shorter than the window
        pulse(25);
        msg_len = 7'd10; restart = 1'b1;
        tick();
        chk("restart_pause_busy", int'(o_busy), 0);
        chk("restart_pause_start", int'(o_start), 0);
        chk("restart_pause_stop", int'(o_stop), 23);
        restart = 1'b0;
        tick();
        wraps = 0;
        for (int i = 0; i < 20; i++) begin
            sclk = 1'b1; tick(); wraps += int'(o_wrap);
            sclk = 1'b0; tick(); wraps += int'(o_wrap);
        end
        chk("static_start", int'(o_start), 0);
        chk("static_stop", int'(o_stop), 23);
        chk("static_wraps", wraps, 0);

`ifdef SCROLL_BOUNCE_EN
        // Bounce over 26 characters
        restart = 1'b1; mode = 1'b1; msg_len = 7'd26;
        tick();
        restart = 1'b0;
        tick();
        pulse(2);
        chk("bounce_end_start", int'(o_start), 2);
        pulse(3);
        sclk = 1'b1; tick();
        chk("bounce_turn_dir", int'(o_dir), 1);
        chk("bounce_turn_start", int'(o_start), 2);
        chk("bounce_turn_wrap", int'(o_wrap), 1);
        sclk = 1'b0; tick();
        pulse(1);
        chk("bounce_back1", int'(o_start), 1);
        pulse(1);
        chk("bounce_back0", int'(o_start), 0);
        mode = 1'b0;
`endif

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            sclk    = 1'($urandom_range(0, 1));
            enable  = ($urandom_range(0, 9) != 0);
            restart = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 39) == 0) begin
                if ($urandom_range(0, 3) == 0) msg_len = 7'($urandom_range(0, 127));
                else msg_len = 7'($urandom_range(0, 40));
                rev  = 1'($urandom_range(0, 1));
                mode = 1'($urandom_range(0, 1));
            end
            tick();
        end

        sclk = 1'b0; restart = 1'b0;
        tick();
        @(negedge clk); #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
